// File: rtl/uart_rx_fifo_pkg.sv
// rtl/uart_rx_fifo_pkg.sv - shared uart drain/load state encoding and defaults
// Purpose: common constants for the uart-side FIFO glue. The drain-state
//          encoding constants are shared with the tx-side loader so both
//          sides decode states identically.
// Contents: DATA_W_DEFAULT, ST_*_ENC encodings, drain_state_e, drain_next().
package uart_rx_fifo_pkg;

  localparam int DATA_W_DEFAULT = 8;

  localparam logic [1:0] ST_IDLE_ENC    = 2'b00;
  localparam logic [1:0] ST_UNLOAD_ENC  = 2'b01;
  localparam logic [1:0] ST_CAPTURE_ENC = 2'b10;

  typedef enum logic [1:0] {
    IDLE    = ST_IDLE_ENC,
    UNLOAD  = ST_UNLOAD_ENC,
    CAPTURE = ST_CAPTURE_ENC
  } drain_state_e;

  // Next-state rule for moving one item from a source (with an empty flag)
  // into a destination (with a full flag). The source is only checked in
  // IDLE; UNLOAD and CAPTURE always proceed so a strobed item is never lost.
  function automatic drain_state_e drain_next(input drain_state_e cur,
                                              input logic src_empty,
                                              input logic dst_full);
    drain_state_e nxt;
    nxt = IDLE;
    case (cur)
      IDLE:    nxt = (!src_empty && !dst_full) ? UNLOAD : IDLE;
      UNLOAD:  nxt = CAPTURE;
      CAPTURE: nxt = IDLE;
      default: nxt = IDLE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/uart_rx_fifo_sync_fifo.sv
// rtl/uart_rx_fifo_sync_fifo.sv - single-clock first-word-fall-through FIFO
// Purpose: circular storage with registered pointers and occupancy count.
// Ports:
//   clk, reset_n       clock and synchronous active-low reset
//   wr_en, wr_data     push (ignored when full)
//   rd_en              pop (ignored when empty)
//   rd_data            head entry, combinational from rd_ptr
//   empty, full, count occupancy flags and count (0..DEPTH)
module sync_fifo #(
  parameter int DATA_W = 8,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              wr_en,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              empty,
  output logic              full,
  output logic [ADDR_W:0]   count
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W + 1)'(DEPTH);
  localparam logic [ADDR_W:0]   CNT_ONE    = {{ADDR_W{1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] PTR_ONE    = {{(ADDR_W - 1){1'b0}}, 1'b1};

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q,  count_d;
  logic              wr_fire;
  logic              rd_fire;

  assign empty   = (count_q == '0);
  assign full    = (count_q == FULL_COUNT);
  assign count   = count_q;
  assign rd_data = mem_q[rd_ptr_q];

  // A pop and a push in the same cycle are both honoured even at count=1:
  // the push lands in a different slot than the one being popped.
  assign wr_fire = wr_en && !full;
  assign rd_fire = rd_en && !empty;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (wr_fire) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_fire) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_fire, rd_fire})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage is not reset; a write requested during reset is dropped.
  always_ff @(posedge clk) begin
    if (reset_n && wr_fire) begin
      mem_q[wr_ptr_q] <= wr_data;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - drains the uart receiver into a host-facing FIFO
// Purpose: watches rx_empty, strobes uld_rx_data, captures rx_data into a
//          FWFT FIFO, and flags host pops attempted while empty.
// Ports:
//   rxclk, reset_n             clock and synchronous active-low reset
//   rx_data, rx_empty          uart holding register and its empty flag
//   uld_rx_data                registered one-cycle unload strobe to uart
//   rd_en, rd_data             host pop request and head-of-FIFO byte
//   fifo_empty/full/count      occupancy status
//   underflow, clr_err         sticky illegal-pop flag and its clear
module uart_rx_fifo
  import uart_rx_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEFAULT,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              rxclk,
  input  logic              reset_n,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_empty,
  output logic              uld_rx_data,
  input  logic              rd_en,
  output logic [DATA_W-1:0] rd_data,
  output logic              fifo_empty,
  output logic              fifo_full,
  output logic [ADDR_W:0]   fifo_count,
  output logic              underflow,
  input  logic              clr_err
);

  drain_state_e state_q, state_d;
  logic         uld_q, uld_d;
  logic         underflow_q, underflow_d;
  logic         wr_en;

  // The uart has already latched its byte and raised rx_empty by the time
  // we reach CAPTURE, so rx_data is stable for the write.
  assign wr_en = (state_q == CAPTURE);

  always_comb begin
    state_d = drain_next(state_q, rx_empty, fifo_full);
    // Strobe is registered: it is high exactly while state_q is UNLOAD.
    uld_d   = (state_d == UNLOAD);
    // An illegal pop in the same cycle as clr_err keeps the flag set.
    if (rd_en && fifo_empty) begin
      underflow_d = 1'b1;
    end else if (clr_err) begin
      underflow_d = 1'b0;
    end else begin
      underflow_d = underflow_q;
    end
  end

  always_ff @(posedge rxclk) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      uld_q       <= 1'b0;
      underflow_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      uld_q       <= uld_d;
      underflow_q <= underflow_d;
    end
  end

  assign uld_rx_data = uld_q;
  assign underflow   = underflow_q;

  sync_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) u_fifo (
    .clk     (rxclk),
    .reset_n (reset_n),
    .wr_en   (wr_en),
    .wr_data (rx_data),
    .rd_en   (rd_en),
    .rd_data (rd_data),
    .empty   (fifo_empty),
    .full    (fifo_full),
    .count   (fifo_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

  localparam int DATA_W = 8;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              rxclk = 1'b0;
  logic              reset_n = 1'b0;
  logic [DATA_W-1:0] rx_data = '0;
  logic              rx_empty = 1'b1;
  logic              uld_rx_data;
  logic              rd_en = 1'b0;
  logic [DATA_W-1:0] rd_data;
  logic              fifo_empty;
  logic              fifo_full;
  logic [ADDR_W:0]   fifo_count;
  logic              underflow;
  logic              clr_err = 1'b0;

  int checks = 0;
  int failures = 0;

  always #5 rxclk = ~rxclk;

  uart_rx_fifo #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .ADDR_W (ADDR_W)
  ) dut (
    .rxclk       (rxclk),
    .reset_n     (reset_n),
    .rx_data     (rx_data),
    .rx_empty    (rx_empty),
    .uld_rx_data (uld_rx_data),
    .rd_en       (rd_en),
    .rd_data     (rd_data),
    .fifo_empty  (fifo_empty),
    .fifo_full   (fifo_full),
    .fifo_count  (fifo_count),
    .underflow   (underflow),
    .clr_err     (clr_err)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Uart receiver model: holds one byte; uld sets rx_empty and keeps rx_data
  // stable through the following capture cycle before loading the next byte.
  logic [DATA_W-1:0] uart_q[$];
  int gap = 0;
  int cyc = 0;
  int last_strobe = -1;

  always @(posedge rxclk) cyc++;

  always @(negedge rxclk) begin
    if (uld_rx_data) begin
      if (last_strobe >= 0) check("strobe_gap", 32'((cyc - last_strobe) >= 3), 32'd1);
      last_strobe = cyc;
      rx_empty = 1'b1;
      gap = 1;
    end else if (gap > 0) begin
      gap--;
    end else if (rx_empty && uart_q.size() > 0) begin
      rx_data = uart_q.pop_front();
      rx_empty = 1'b0;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge rxclk);
  endtask

  task automatic wait_uld(input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 60 && !found; k++) begin
      @(negedge rxclk);
      if (uld_rx_data) found = 1'b1;
    end
    if (!found) check(tag, 32'd0, 32'd1);
  endtask

  task automatic wait_count(input int n, input string tag);
    bit found = 1'b0;
    for (int k = 0; k < 400 && !found; k++) begin
      @(negedge rxclk);
      if (fifo_count == (ADDR_W + 1)'(n)) found = 1'b1;
    end
    if (!found) check(tag, 32'(fifo_count), 32'(n));
  endtask

  task automatic pop_expect(input string tag, input logic [DATA_W-1:0] exp);
    check(tag, 32'(rd_data), 32'(exp));
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic [DATA_W-1:0] hello [5];
    bit seen;
    hello[0] = 8'h48; hello[1] = 8'h65; hello[2] = 8'h6C; hello[3] = 8'h6C; hello[4] = 8'h6F;

    // Reset state
    reset_n = 1'b0;
    tick(2);
    check("rst_count", 32'(fifo_count), 32'd0);
    check("rst_empty", 32'(fifo_empty), 32'd1);
    check("rst_full", 32'(fifo_full), 32'd0);
    check("rst_uld", 32'(uld_rx_data), 32'd0);
    check("rst_underflow", 32'(underflow), 32'd0);
    reset_n = 1'b1;
    tick(2);

    // Underflow handling
    rd_en = 1'b1; tick(1); rd_en = 1'b0;
    check("uf_set", 32'(underflow), 32'd1);
    check("uf_count", 32'(fifo_count), 32'd0);
    check("uf_empty", 32'(fifo_empty), 32'd1);
    clr_err = 1'b1; tick(1); clr_err = 1'b0;
    check("uf_clr", 32'(underflow), 32'd0);
    clr_err = 1'b1; rd_en = 1'b1; tick(1); clr_err = 1'b0; rd_en = 1'b0;
    check("uf_set_wins", 32'(underflow), 32'd1);
    uart_q.push_back(8'h77);
    wait_count(1, "uf_push_timeout");
    check("uf_ptr_data", 32'(rd_data), 32'h77);
    pop_expect("uf_pop", 8'h77);
    check("uf_pop_empty", 32'(fifo_empty), 32'd1);

    // Reset during CAPTURE discards the byte in flight
    uart_q.push_back(8'hAA);
    wait_uld("rc_uld_timeout");
    tick(1);
    reset_n = 1'b0;
    tick(2);
    check("rc_count", 32'(fifo_count), 32'd0);
    check("rc_empty", 32'(fifo_empty), 32'd1);
    check("rc_uld", 32'(uld_rx_data), 32'd0);
    check("rc_underflow", 32'(underflow), 32'd0);
    reset_n = 1'b1;
    tick(3);
    check("rc_no_write", 32'(fifo_count), 32'd0);

    // Single byte, capture latency
    uart_q.push_back(8'h41);
    wait_uld("sb_uld_timeout");
    tick(1);
    check("sb_uld_one_cycle", 32'(uld_rx_data), 32'd0);
    tick(1);
    check("sb_count", 32'(fifo_count), 32'd1);
    check("sb_data", 32'(rd_data), 32'h41);
    pop_expect("sb_pop", 8'h41);
    check("sb_empty", 32'(fifo_empty), 32'd1);

    // Burst "Hello"
    for (int i = 0; i < 5; i++) uart_q.push_back(hello[i]);
    wait_count(5, "burst_timeout");
    for (int i = 0; i < 5; i++) pop_expect($sformatf("burst_%0d", i), hello[i]);
    check("burst_empty", 32'(fifo_empty), 32'd1);

    // Full stall
    for (int i = 0; i < DEPTH; i++) uart_q.push_back(8'(8'h10 + i));
    wait_count(DEPTH, "full_timeout");
    check("full_flag", 32'(fifo_full), 32'd1);
    uart_q.push_back(8'h55);
    tick(3);
    seen = 1'b0;
    repeat (10) begin
      tick(1);
      if (uld_rx_data) seen = 1'b1;
    end
    check("full_no_uld", 32'(seen), 32'd0);
    check("full_rx_held", 32'(rx_empty), 32'd0);
    check("full_count", 32'(fifo_count), 32'd16);
    pop_expect("full_pop0", 8'h10);
    wait_uld("full_uld_timeout");
    tick(2);
    check("full_refill_count", 32'(fifo_count), 32'd16);
    check("full_refill_flag", 32'(fifo_full), 32'd1);
    for (int i = 1; i < DEPTH; i++) pop_expect($sformatf("full_pop%0d", i), 8'(8'h10 + i));
    pop_expect("full_pop_55", 8'h55);
    check("full_drained", 32'(fifo_empty), 32'd1);

    // Pop in the same cycle as CAPTURE at count=1
    uart_q.push_back(8'h30);
    wait_count(1, "sim_timeout");
    uart_q.push_back(8'h42);
    wait_uld("sim_uld_timeout");
    check("sim_head", 32'(rd_data), 32'h30);
    tick(1);
    rd_en = 1'b1;
    tick(1);
    rd_en = 1'b0;
    check("sim_count", 32'(fifo_count), 32'd1);
    check("sim_data", 32'(rd_data), 32'h42);
    pop_expect("sim_pop", 8'h42);
    check("sim_empty", 32'(fifo_empty), 32'd1);
    check("sim_no_uf", 32'(underflow), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
